// File: rtl/fcs_mpc_sequencer.sv
// ============================================================================
// Module   : fcs_mpc_sequencer
// Brief    : Finite-control-set MPC decision sequencer with one shared 16x8
//            multiplier; optional minimum-dwell hold enabled by FCS_DWELL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fcs_mpc_sequencer #(
    parameter logic [15:0] K_IL  = 16'd120,
    parameter logic [15:0] K_VC  = 16'd115,
    parameter logic [15:0] K_VG  = 16'd7,
    parameter logic [31:0] I_REF = 32'd40000
`ifdef FCS_DWELL_EN
    ,
    parameter logic [7:0]  MIN_DWELL = 8'd4
`endif
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        en,
    input  logic [15:0] period,
    input  logic [7:0]  iL,
    input  logic [7:0]  vc,
    input  logic [7:0]  vg,
    output logic        u,
    output logic        u_valid,
    output logic        busy,
    output logic        overrun,
    output logic [24:0] io_oeb
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MUL_IL = 3'd1,
        S_MUL_VC = 3'd2,
        S_MUL_VG = 3'd3,
        S_DECIDE = 3'd4
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [7:0]  r_il;
    logic [7:0]  r_vc;
    logic [7:0]  r_vg;
    logic [31:0] r_acc;
    logic [31:0] r_p;
    logic        r_u;
    logic        r_u_valid;
    logic        r_busy;
    logic        r_overrun;
`ifdef FCS_DWELL_EN
    logic [7:0]  r_dwell;
`endif

    logic        w_tick;
    logic [15:0] w_mul_a;
    logic [7:0]  w_mul_b;
    logic [23:0] w_prod;
    logic [31:0] w_sum;
    logic [31:0] w_cost0;
    logic [31:0] w_cost1;
    logic        w_u_next;

    // |x| with the most negative value clamped so the cost stays positive
    function automatic logic [31:0] f_abs(input logic [31:0] x);
        if (x == 32'h8000_0000)
            return 32'h7FFF_FFFF;
        else if (x[31])
            return -x;
        else
            return x;
    endfunction

    assign w_tick = en && (r_cnt == period);

    always_comb begin
        w_mul_a = K_VG;
        w_mul_b = r_vg;
        case (r_state)
            S_MUL_IL: begin
                w_mul_a = K_IL;
                w_mul_b = r_il;
            end
            S_MUL_VC: begin
                w_mul_a = K_VC;
                w_mul_b = r_vc;
            end
            default: begin
                w_mul_a = K_VG;
                w_mul_b = r_vg;
            end
        endcase
    end

    assign w_prod   = {8'd0, w_mul_a} * {16'd0, w_mul_b};
    assign w_sum    = r_acc + r_p;
    assign w_cost0  = f_abs(r_acc);
    assign w_cost1  = f_abs(w_sum);
    assign w_u_next = (w_cost1 <= w_cost0);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_il      <= 8'd0;
            r_vc      <= 8'd0;
            r_vg      <= 8'd0;
            r_acc     <= 32'd0;
            r_p       <= 32'd0;
            r_u       <= 1'b0;
            r_u_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
`ifdef FCS_DWELL_EN
            r_dwell   <= 8'd0;
`endif
        end else begin
            if (!en)
                r_cnt <= 16'd0;
            else if (w_tick)
                r_cnt <= 16'd0;
            else
                r_cnt <= r_cnt + 16'd1;

            r_u_valid <= 1'b0;

            // a tick that arrives mid-evaluation is dropped, never queued
            if (w_tick && (r_state != S_IDLE))
                r_overrun <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_il    <= iL;
                        r_vc    <= vc;
                        r_vg    <= vg;
                        r_busy  <= 1'b1;
                        r_state <= S_MUL_IL;
                    end
                end
                S_MUL_IL: begin
                    r_acc   <= {8'd0, w_prod} - I_REF;
                    r_state <= S_MUL_VC;
                end
                S_MUL_VC: begin
                    r_acc   <= r_acc + {8'd0, w_prod};
                    r_state <= S_MUL_VG;
                end
                S_MUL_VG: begin
                    r_p     <= {8'd0, w_prod};
                    r_state <= S_DECIDE;
                end
                S_DECIDE: begin
`ifdef FCS_DWELL_EN
                    if ((w_u_next != r_u) && (r_dwell >= MIN_DWELL)) begin
                        r_u     <= w_u_next;
                        r_dwell <= 8'd0;
                    end else if (r_dwell != 8'hFF) begin
                        r_dwell <= r_dwell + 8'd1;
                    end
`else
                    r_u <= w_u_next;
`endif
                    r_u_valid <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign u       = r_u;
    assign u_valid = r_u_valid;
    assign busy    = r_busy;
    assign overrun = r_overrun;
    assign io_oeb  = 25'h1FF_FFFE;

endmodule

`default_nettype wire

// File: tb/tb_fcs_mpc_sequencer.sv
// ============================================================================
// Module   : tb_fcs_mpc_sequencer
// Brief    : Self-checking bench; cycle model of counter/busy plus a u scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fcs_mpc_sequencer;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] period;
    logic [7:0]  il, vc, vg;
    logic        u, u_valid, busy, overrun;
    logic [24:0] io_oeb;

    fcs_mpc_sequencer dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .en       (en),
        .period   (period),
        .iL       (il),
        .vc       (vc),
        .vg       (vg),
        .u        (u),
        .u_valid  (u_valid),
        .busy     (busy),
        .overrun  (overrun),
        .io_oeb   (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] il;
        logic [7:0] vc;
        logic [7:0] vg;
        logic       u;
    } vec_t;

    typedef struct {
        int   due;
        logic u;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic        m_known = 1'b0;
    logic [15:0] m_cnt;
    int          m_left;
    logic        m_ovr;
    logic        m_u;
    int          m_dwell;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // decision reference computed with wide signed arithmetic
    function automatic logic f_unext(input int a, input int b, input int c);
        longint acc, p, c0, c1;
        acc = 120 * a + 115 * b - 40000;
        p   = 7 * c;
        c0  = (acc < 0) ? -acc : acc;
        c1  = ((acc + p) < 0) ? -(acc + p) : (acc + p);
        return (c1 <= c0);
    endfunction

    always @(negedge clk) begin
        if (m_known) begin
            if (u_valid === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_u_valid cyc=%0d actual u_valid=1 required u_valid=0", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ((e.due != cyc) || (u !== e.u)) begin
                        n_bad++;
                        $display("FAIL decision cyc=%0d actual u=%b required u=%b at cyc=%0d",
                                 cyc, u, e.u, e.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_u_valid cyc=%0d actual u_valid=%b required u_valid=1", cyc, u_valid);
                void'(sb.pop_front());
            end
        end
    end

    // one cycle: apply inputs, check busy/overrun, step the model, advance the clock
    task automatic drive(input logic r, input logic e, input logic [15:0] per,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic un);
        logic tick, acc_ok, drop;
        exp_t x;
        rst = r; en = e; period = per; il = a; vc = b; vg = c;
        if (m_known && !r) begin
            chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        end
        tick   = !r && e && (m_cnt == per);
        acc_ok = tick && (m_left == 0);
        drop   = tick && (m_left > 0);
        if (acc_ok) begin
`ifdef FCS_DWELL_EN
            if ((un != m_u) && (m_dwell >= 4)) begin
                m_u     = un;
                m_dwell = 0;
            end else if (m_dwell < 255) begin
                m_dwell++;
            end
`else
            m_u = un;
`endif
            x.due = cyc + 5;
            x.u   = m_u;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_cnt = 16'd0; m_left = 0; m_ovr = 1'b0; m_u = 1'b0; m_dwell = 0;
            sb.delete();
            m_known = 1'b1;
        end else begin
            m_cnt = (!e || tick) ? 16'd0 : m_cnt + 16'd1;
            if (acc_ok) m_left = 4;
            else if (m_left > 0) m_left--;
            if (drop) m_ovr = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'd0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    endtask

    // single tick (period 0, en for one cycle) then scrambled inputs while it evaluates
    task automatic eval(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic un);
        drive(1'b0, 1'b1, 16'd0, a, b, c, un);
        idle(6);
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{8'd0,   8'd0,   8'd10,  1'b1};
        tbl[1] = '{8'd255, 8'd255, 8'd10,  1'b0};
        tbl[2] = '{8'd255, 8'd255, 8'd0,   1'b1};
        tbl[3] = '{8'd200, 8'd0,   8'd0,   1'b1};
        tbl[4] = '{8'd200, 8'd0,   8'd255, 1'b1};
        tbl[5] = '{8'd255, 8'd255, 8'd255, 1'b0};
        tbl[6] = '{8'd100, 8'd100, 8'd50,  1'b1};
        tbl[7] = '{8'd170, 8'd170, 8'd100, 1'b0};
        tbl[8] = '{8'd170, 8'd171, 8'd3,   1'b0};

        rst = 1'b1; en = 1'b0; period = 16'd0; il = 8'd0; vc = 8'd0; vg = 8'd0;
        m_cnt = 16'd0; m_left = 0; m_ovr = 1'b0; m_u = 1'b0; m_dwell = 0;
        repeat (2) @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 16'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        chk("reset_u", {31'd0, u}, 32'd0);
        chk("reset_u_valid", {31'd0, u_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        chk("io_oeb", {7'd0, io_oeb}, 32'h01FF_FFFE);

        for (int i = 0; i < 9; i++) eval(tbl[i].il, tbl[i].vc, tbl[i].vg, tbl[i].u);

        for (int i = 0; i < 6; i++) begin
            logic [7:0] a, b, c;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            c = 8'($urandom_range(0, 255));
            eval(a, b, c, f_unext(int'(a), int'(b), int'(c)));
        end

        // free-running period of 10 cycles
        for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, 16'd9, 8'd0, 8'd0, 8'd10, 1'b1);
        idle(8);

        // alternating decisions once u is 1
        eval(8'd0, 8'd0, 8'd10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            eval(8'd255, 8'd255, 8'd10, 1'b0);
            eval(8'd0,   8'd0,   8'd10, 1'b1);
        end

        // ticks every 3 cycles land while busy
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 16'd2, 8'd255, 8'd255, 8'd10, 1'b0);
        idle(10);
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);
        drive(1'b1, 1'b0, 16'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        chk("overrun_cleared", {31'd0, overrun}, 32'd0);

        // reset during MUL_VC aborts the evaluation
        eval(8'd0, 8'd0, 8'd10, 1'b1);
        drive(1'b0, 1'b1, 16'd0, 8'd255, 8'd255, 8'd0, 1'b1);
        drive(1'b0, 1'b0, 16'd0, 8'd1, 8'd2, 8'd3, 1'b0);
        drive(1'b1, 1'b0, 16'd0, 8'd1, 8'd2, 8'd3, 1'b0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_u", {31'd0, u}, 32'd0);
        idle(6);
        eval(8'd0, 8'd0, 8'd10, 1'b1);
        eval(8'd255, 8'd255, 8'd10, 1'b0);

        idle(4);
        chk("scoreboard_drained", sb.size(), 32'd0);
        chk("io_oeb_end", {7'd0, io_oeb}, 32'h01FF_FFFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fcs_mpc_sequencer.md
FCS_MPC_SEQUENCER -- requirements
Module: fcs_mpc_sequencer

Interface
REQ-001 Parameter K_IL, 16'd120, unsigned iL weight.
REQ-002 Parameter K_VC, 16'd115, unsigned vc weight.
REQ-003 Parameter K_VG, 16'd7, unsigned vg weight.
REQ-004 Parameter I_REF, 32'd40000, reference offset subtracted from the predicted error.
REQ-005 Parameter MIN_DWELL, 8'd4, minimum decisions between u changes (used only with FCS_DWELL_EN).
REQ-006 wb_clk_i  in  1  single clock; all logic on its rising edge.
REQ-007 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-008 en  in  1  enables the sample-period counter.
REQ-009 period  in  16  sample interval minus one, in clock cycles.
REQ-010 iL, vc, vg  in  8 each  unsigned measurements, sampled on tick.
REQ-011 u  out  1  registered switch command.
REQ-012 u_valid  out  1  one-cycle pulse when a decision is written to u.
REQ-013 busy  out  1  high while the FSM is not IDLE.
REQ-014 overrun  out  1  sticky; set when a tick arrives while busy.
REQ-015 io_oeb  out  25  bit 0 = 0; bits 24:1 = 1, constant.

Function
REQ-016 Counter: when en=1 and cnt==period, cnt<=0 and tick=1; otherwise, when en=1, cnt<=cnt+1; when en=0, cnt<=0 and no tick.
REQ-017 FSM states IDLE, MUL_IL, MUL_VC, MUL_VG, DECIDE; IDLE->MUL_IL on tick, then one state per cycle, DECIDE->IDLE unconditionally.
REQ-018 On a tick accepted in IDLE, iL/vc/vg are latched in that cycle; later input changes do not affect the evaluation.
REQ-019 Exactly one 16x8 unsigned multiplier is shared, time-multiplexed: MUL_IL acc<=K_IL*iL - I_REF; MUL_VC acc<=acc+K_VC*vc; MUL_VG p<=K_VG*vg.
REQ-020 acc is 32-bit two's complement; products are zero-extended to 32 bits; wrap-around is not checked.
REQ-021 DECIDE: cost0=|acc|, cost1=|acc+p|; abs(32'h80000000) saturates to 32'h7FFFFFFF; u_next=(cost1<=cost0), so a tie gives 1.
REQ-022 u is updated at the end of DECIDE; u and u_valid are visible 5 cycles after the tick cycle.
REQ-023 A tick while busy is dropped and sets overrun; only reset clears overrun.
REQ-024 When en falls mid-evaluation, the evaluation completes and u_valid still pulses.
REQ-025 busy=1 in MUL_IL through DECIDE, 0 in IDLE.

Reset
REQ-026 While wb_rst_i=1 at a clock edge: state=IDLE, cnt=0, acc=0, p=0, u=0, u_valid=0, busy=0, overrun=0, dwell counter=0.
REQ-027 Reset mid-evaluation aborts the evaluation with no u_valid pulse.

Configuration
REQ-028 With FCS_DWELL_EN defined: a dwell counter increments (saturating at 255) on each decision and clears when u changes; when u_next!=u and dwell<MIN_DWELL, u is held, and u_valid still pulses.
REQ-029 Without FCS_DWELL_EN: u<=u_next on every decision, and no dwell logic is present.

Verification
REQ-030 period=9, en=1 held -> ticks every 10 cycles, u_valid 5 cycles after each tick, busy high for 4 cycles.
REQ-031 iL=0, vc=0, vg=10 -> acc=-40000, cost1=39930 -> u=1.
REQ-032 iL=255, vc=255, vg=10 -> acc=19925, cost1=19995 -> u=0; same inputs with vg=0 -> tie -> u=1.
REQ-033 period=2 -> the second tick lands while busy -> overrun=1 and stays 1 until wb_rst_i.
REQ-034 FCS_DWELL_EN, MIN_DWELL=4, inputs alternating between the REQ-031 and REQ-032 (vg=10) cases after u has gone to 1 -> u holds for 4 decisions, then changes; without the macro, u toggles on every decision.
REQ-035 wb_rst_i pulsed in MUL_VC -> next cycle IDLE, u=0, no u_valid, and the next tick evaluates correctly.
